// File: rtl/buf_ctrl_pkg.sv
// Shared types and helpers for the ping-pong update-buffer write controller.
package buf_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    BUSY  = 2'd2
  } bank_state_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } ctrl_state_e;

  // Requested word count limited to the bank depth.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/buf_bank_tracker.sv
// Per-bank EMPTY/FULL/BUSY tracking, execute-side offer/take/done handshake and sticky error.
module buf_bank_tracker
  import buf_ctrl_pkg::*;
#(
  parameter int BUF_UPDT_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit,
  input  logic                         commit_bank,
  input  logic [BUF_UPDT_ADDR_WIDTH:0] commit_len,
  output logic [1:0]                   bank_empty,
  output logic                         exec_valid,
  input  logic                         exec_ready,
  output logic                         exec_sel,
  output logic [BUF_UPDT_ADDR_WIDTH:0] exec_len,
  input  logic                         exec_done,
  output logic                         err
);

  bank_state_e                  bank_st  [2];
  logic [BUF_UPDT_ADDR_WIDTH:0] bank_len [2];
  logic                         rd_bank;
  logic                         done_bank;

  assign bank_empty[0] = (bank_st[0] == EMPTY);
  assign bank_empty[1] = (bank_st[1] == EMPTY);
  assign exec_valid    = (bank_st[rd_bank] == FULL);
  assign exec_sel      = rd_bank;
  assign exec_len      = bank_len[rd_bank];

  // Commit hits an EMPTY bank, the take a FULL one and done a BUSY one, so all
  // three can land in the same cycle without ever targeting the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        bank_st[i]  <= EMPTY;
        bank_len[i] <= '0;
      end
      rd_bank   <= 1'b0;
      done_bank <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (commit) begin
        bank_st[commit_bank]  <= FULL;
        bank_len[commit_bank] <= commit_len;
      end
      if (exec_valid && exec_ready) begin
        bank_st[rd_bank] <= BUSY;
        rd_bank          <= ~rd_bank;
      end
      if (exec_done) begin
        if (bank_st[done_bank] == BUSY) begin
          bank_st[done_bank] <= EMPTY;
          done_bank          <= ~done_bank;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/buf_updt_ctrl.sv
// Write-side controller for the ping-pong update/execute buffer: load FSM,
// address counter and registered RAM write-port signals.
module buf_updt_ctrl
  import buf_ctrl_pkg::*;
#(
  parameter int BUF_UPDT_ADDR_WIDTH = 8,
  parameter int BUF_UPDT_DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [BUF_UPDT_ADDR_WIDTH:0]       cmd_len,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [BUF_UPDT_DATA_WIDTH-1:0]     s_data,
  input  logic [BUF_UPDT_DATA_WIDTH/8-1:0]   s_strb,
  output logic [BUF_UPDT_DATA_WIDTH/8-1:0]   buf_updt_wr_en,
  output logic                               buf_updt_sel,
  output logic [BUF_UPDT_ADDR_WIDTH-1:0]     buf_updt_addr,
  output logic [BUF_UPDT_DATA_WIDTH-1:0]     buf_updt_data,
  output logic                               exec_valid,
  input  logic                               exec_ready,
  output logic                               exec_sel,
  output logic [BUF_UPDT_ADDR_WIDTH:0]       exec_len,
  input  logic                               exec_done,
  output logic                               err
);

  localparam int          AW    = BUF_UPDT_ADDR_WIDTH;
  localparam int          LW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  ctrl_state_e   state;
  logic          wr_bank;
  logic [AW:0]   len;
  logic [AW-1:0] cnt;
  logic [1:0]    bank_empty;
  logic [AW:0]   cmd_len_clamped;
  logic          cmd_acc;
  logic          beat_acc;
  logic          last_beat;
  logic          commit;

  assign cmd_len_clamped = LW'(clamp_len(32'(cmd_len), DEPTH));
  assign cmd_ready       = (state == IDLE) && bank_empty[wr_bank];
  assign s_ready         = (state == FILL);
  assign cmd_acc         = cmd_valid && cmd_ready;
  assign beat_acc        = s_valid && s_ready;
  assign last_beat       = ({1'b0, cnt} == (len - 1'b1));
  assign commit          = (state == COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_bank <= 1'b0;
      len     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            len   <= cmd_len_clamped;
            cnt   <= '0;
            state <= (cmd_len_clamped != '0) ? FILL : COMMIT;
          end
        end
        FILL: begin
          if (beat_acc) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= COMMIT;
          end
        end
        COMMIT: begin
          wr_bank <= ~wr_bank;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write enables pulse only for accepted beats; sel/addr/data hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_updt_wr_en <= '0;
      buf_updt_sel   <= 1'b0;
      buf_updt_addr  <= '0;
      buf_updt_data  <= '0;
    end else if (beat_acc) begin
      buf_updt_wr_en <= s_strb;
      buf_updt_sel   <= wr_bank;
      buf_updt_addr  <= cnt;
      buf_updt_data  <= s_data;
    end else begin
      buf_updt_wr_en <= '0;
    end
  end

  buf_bank_tracker #(
    .BUF_UPDT_ADDR_WIDTH(BUF_UPDT_ADDR_WIDTH)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .commit     (commit),
    .commit_bank(wr_bank),
    .commit_len (len),
    .bank_empty (bank_empty),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .exec_sel   (exec_sel),
    .exec_len   (exec_len),
    .exec_done  (exec_done),
    .err        (err)
  );

endmodule

// File: tb/tb_buf_updt_ctrl.sv
// Self-checking bench for buf_updt_ctrl: table of loads plus hand-written ping-pong, error and reset sequences.
module tb_buf_updt_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int B  = DW / 8;
  localparam int D  = 1 << AW;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          cmd_valid  = 1'b0;
  logic          cmd_ready;
  logic [AW:0]   cmd_len    = '0;
  logic          s_valid    = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data     = '0;
  logic [B-1:0]  s_strb     = '0;
  logic [B-1:0]  buf_updt_wr_en;
  logic          buf_updt_sel;
  logic [AW-1:0] buf_updt_addr;
  logic [DW-1:0] buf_updt_data;
  logic          exec_valid;
  logic          exec_ready = 1'b0;
  logic          exec_sel;
  logic [AW:0]   exec_len;
  logic          exec_done  = 1'b0;
  logic          err;

  buf_updt_ctrl #(
    .BUF_UPDT_ADDR_WIDTH(AW),
    .BUF_UPDT_DATA_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_strb        (s_strb),
    .buf_updt_wr_en(buf_updt_wr_en),
    .buf_updt_sel  (buf_updt_sel),
    .buf_updt_addr (buf_updt_addr),
    .buf_updt_data (buf_updt_data),
    .exec_valid    (exec_valid),
    .exec_ready    (exec_ready),
    .exec_sel      (exec_sel),
    .exec_len      (exec_len),
    .exec_done     (exec_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [B-1:0]  strb;
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [AW:0]  cmd_len;
    logic [B-1:0] strb_even;
    logic [B-1:0] strb_odd;
    logic [AW:0]  exp_len;
    int unsigned  exp_writes;
  } vec_t;

  beat_t       exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned nz_cnt   = 0;
  logic        mdl_bank = 1'b0;
  logic        acc_d    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) acc_d <= 1'b0;
    else     acc_d <= s_valid && s_ready;
  end

  always @(negedge clk) begin : mon
    beat_t b;
    if (acc_d) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        b = exp_q.pop_front();
        check("wr_en", 64'(buf_updt_wr_en), 64'(b.strb));
        check("sel",   64'(buf_updt_sel),   64'(b.sel));
        check("addr",  64'(buf_updt_addr),  64'(b.addr));
        check("data",  64'(buf_updt_data),  64'(b.data));
      end
    end else begin
      check("wr_en_idle", 64'(buf_updt_wr_en), 64'(0));
    end
    if (buf_updt_wr_en != '0) nz_cnt++;
  end

  // Drives one load; returns at the negedge one cycle after COMMIT.
  task automatic do_load(input logic [AW:0] cl, input logic [B-1:0] s0, input logic [B-1:0] s1,
                         input bit chk_tim, input logic [AW:0] elen);
    int unsigned n;
    int unsigned k;
    n = (int'(cl) > D) ? D : int'(cl);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = cl;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_strb  = i[0] ? s1 : s0;
      s_data  = 32'h11111111 * (i + 1);
      check("s_ready_fill", 64'(s_ready), 64'(1));
      exp_q.push_back('{strb: s_strb, sel: mdl_bank, addr: AW'(i), data: s_data});
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_strb  = '0;
    check("s_ready_commit", 64'(s_ready), 64'(0));
    if (chk_tim) check("exec_valid_early", 64'(exec_valid), 64'(0));
    @(negedge clk);
    if (chk_tim) begin
      check("exec_valid", 64'(exec_valid), 64'(1));
      check("exec_sel",   64'(exec_sel),   64'(mdl_bank));
      check("exec_len",   64'(exec_len),   64'(elen));
    end
    mdl_bank = ~mdl_bank;
  endtask

  task automatic take(input logic exp_sel, input logic [AW:0] exp_len);
    int unsigned k;
    k = 0;
    while (!exec_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("take_valid", 64'(exec_valid), 64'(1));
    check("take_sel",   64'(exec_sel),   64'(exp_sel));
    check("take_len",   64'(exec_len),   64'(exp_len));
    exec_ready = 1'b1;
    @(negedge clk);
    exec_ready = 1'b0;
  endtask

  task automatic pulse_done();
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  initial begin
    vec_t        vecs[6];
    int unsigned nz0;
    logic        sel_v;

    vecs[0] = '{cmd_len: 9'd4,       strb_even: 4'hF, strb_odd: 4'hF, exp_len: 9'd4,   exp_writes: 4};
    vecs[1] = '{cmd_len: 9'd2,       strb_even: 4'h5, strb_odd: 4'h0, exp_len: 9'd2,   exp_writes: 1};
    vecs[2] = '{cmd_len: 9'd0,       strb_even: 4'hF, strb_odd: 4'hF, exp_len: 9'd0,   exp_writes: 0};
    vecs[3] = '{cmd_len: 9'(D + 5),  strb_even: 4'hF, strb_odd: 4'hF, exp_len: 9'(D), exp_writes: D};
    vecs[4] = '{cmd_len: 9'd1,       strb_even: 4'hF, strb_odd: 4'hF, exp_len: 9'd1,   exp_writes: 1};
    vecs[5] = '{cmd_len: 9'd3,       strb_even: 4'hA, strb_odd: 4'h3, exp_len: 9'd3,   exp_writes: 3};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",  64'(cmd_ready),  64'(1));
    check("rst_s_ready",    64'(s_ready),    64'(0));
    check("rst_exec_valid", 64'(exec_valid), 64'(0));
    check("rst_exec_sel",   64'(exec_sel),   64'(0));
    check("rst_exec_len",   64'(exec_len),   64'(0));
    check("rst_err",        64'(err),        64'(0));
    check("rst_sel",        64'(buf_updt_sel),  64'(0));
    check("rst_addr",       64'(buf_updt_addr), 64'(0));
    check("rst_data",       64'(buf_updt_data), 64'(0));
    rst = 1'b0;

    for (int unsigned v = 0; v < 6; v++) begin
      nz0   = nz_cnt;
      sel_v = mdl_bank;
      do_load(vecs[v].cmd_len, vecs[v].strb_even, vecs[v].strb_odd, 1'b1, vecs[v].exp_len);
      take(sel_v, vecs[v].exp_len);
      check("write_count", 64'(nz_cnt - nz0), 64'(vecs[v].exp_writes));
      pulse_done();
      check("freed_cmd_ready", 64'(cmd_ready), 64'(1));
      check("no_err", 64'(err), 64'(0));
    end

    // Ping-pong: bank 0 taken, bank 1 filled, third command stalls until done.
    do_load(9'd1, 4'hF, 4'hF, 1'b1, 9'd1);
    take(1'b0, 9'd1);
    do_load(9'd2, 4'hF, 4'hF, 1'b1, 9'd2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 9'd1;
    repeat (3) begin
      @(negedge clk);
      check("stall_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    exec_done = 1'b1;
    check("done_cycle_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    exec_done = 1'b0;
    cmd_valid = 1'b0;
    check("after_done_cmd_ready", 64'(cmd_ready), 64'(1));
    check("pp_model_bank", 64'(mdl_bank), 64'(0));
    do_load(9'd1, 4'hF, 4'hF, 1'b0, 9'd1);
    take(1'b1, 9'd2);
    pulse_done();
    take(1'b0, 9'd1);
    pulse_done();

    // exec_done with no BUSY bank.
    pulse_done();
    check("err_set",          64'(err),        64'(1));
    check("err_exec_valid",   64'(exec_valid), 64'(0));
    check("err_cmd_ready",    64'(cmd_ready),  64'(1));
    repeat (3) @(negedge clk);
    check("err_sticky",       64'(err),        64'(1));

    // Reset in the middle of a 4-beat fill.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 9'd4;
    check("mid_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_strb  = 4'hF;
      s_data  = 32'hA0A0A0A0 + i;
      exp_q.push_back('{strb: s_strb, sel: mdl_bank, addr: AW'(i), data: s_data});
      @(negedge clk);
    end
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_en",      64'(buf_updt_wr_en), 64'(0));
    check("mid_rst_sel",        64'(buf_updt_sel),   64'(0));
    check("mid_rst_addr",       64'(buf_updt_addr),  64'(0));
    check("mid_rst_data",       64'(buf_updt_data),  64'(0));
    check("mid_rst_cmd_ready",  64'(cmd_ready),      64'(1));
    check("mid_rst_s_ready",    64'(s_ready),        64'(0));
    check("mid_rst_exec_valid", 64'(exec_valid),     64'(0));
    check("mid_rst_exec_len",   64'(exec_len),       64'(0));
    check("mid_rst_err",        64'(err),            64'(0));
    check("mid_rst_sb_empty",   64'(exp_q.size()),   64'(0));
    @(negedge clk);
    rst      = 1'b0;
    mdl_bank = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_exec_valid", 64'(exec_valid), 64'(0));
    end
    do_load(9'd1, 4'hF, 4'hF, 1'b1, 9'd1);
    take(1'b0, 9'd1);
    pulse_done();

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
